sdes_iter_core: RTL and testbench
=================================

Name: sdes_iter_core

Overview:
- Iterative, parametrised S-DES engine that executes one Feistel round per clock using a registered round datapath.
- Generalises the combinational single-round fk function:
  - configurable round count;
  - encrypt/decrypt mode;
  - on-the-fly key schedule from a 10-bit key;
  - valid/ready handshake on both sides.
- Sits between the byte-stream front end and the result buffer of the crypto datapath.

Parameters:
- ROUNDS, default 2, number of Feistel rounds (legal 1..16). ROUNDS=2 is bit-exact textbook S-DES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  core can accept; equals (state==IDLE) and !rst.
- in_data  in  [0:7]  plaintext or ciphertext block.
- in_key  in  [0:9]  10-bit key.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  [0:7]  result block.
- busy  out  1  high in ROUND state.

Behaviour:
- Bit numbering: table entry n refers to vector index n-1; index 0 is the MSB.
- Tables (standard S-DES):
  - P10 = 3 5 2 7 4 10 1 9 8 6
  - P8 = 6 3 7 4 8 5 10 9
  - IP = 2 6 3 1 4 8 5 7
  - IP^-1 = 4 1 3 5 7 2 8 6
  - EP = 4 1 2 3 2 3 4 1
  - P4 = 2 4 3 1
  - S0 rows: 1032 / 3210 / 0213 / 3132
  - S1 rows: 0123 / 2013 / 3010 / 2103
  - S-box row = bits 1,4; column = bits 2,3 of its 4-bit input.
- Round function: fk(L,R,K) = {L ^ P4(S0(x[0:3]),S1(x[4:7])), R}, where x = EP(R) ^ K.
- Key schedule:
  - P10(in_key) splits into 5-bit halves.
  - Encrypt round r (1-based) rotates both halves left by 1 if r==1, else by 2, cumulatively. Subkey Kr = P8 of the rotated halves.
  - Decrypt uses K_ROUNDS..K1. Start the halves at the cumulative left-rotation S = (1+2*(ROUNDS-1)) mod 5. After using a subkey, rotate right by that encrypt round's amount.
  - One key-state register; no subkey storage array.
- FSM states: IDLE, ROUND, DONE.
  - IDLE: in_ready=1. On in_valid, sample in_data/in_key/in_decrypt, load state = IP(in_data), load key halves, round count = 0, go to ROUND.
  - ROUND: each cycle apply fk with the current subkey.
    - Not the last round: swap halves, advance the key state, increment the count.
    - Last round: no swap; out_data <= IP^-1(result); out_valid <= 1; go to DONE.
  - DONE: hold out_data/out_valid stable until out_ready=1. At that edge clear out_valid and go to IDLE.
- Latency: accept at edge T gives out_valid high after edge T+ROUNDS. Throughput is one block per ROUNDS+2 cycles minimum.
- No overlap: in_ready stays low in DONE even when out_ready=1 in the same cycle. A new accept is possible only from IDLE on the following cycle.
- Input changes after accept are ignored.
- Reset (at any state, including mid-ROUND):
  - state=IDLE, out_valid=0, out_data=8'h00, busy=0, key/data registers=0, in_ready=0 while rst is high;
  - any in-flight block is discarded with no output.
- out_data is only meaningful while out_valid=1; it retains the last result in IDLE.

Optional Feature:
- Macro SDES_ABORT_EN.
- Defined:
  - adds input abort (1 bit);
  - abort=1 in ROUND or DONE returns to IDLE at the next edge, clears out_valid and busy, and drops the block;
  - abort has priority over out_ready and round completion;
  - abort in IDLE is ignored, and in_valid is not accepted in that cycle.
- Undefined: no abort port; behaviour exactly as above.

Test Plan:
- ROUNDS=2, encrypt, key 1010000010, data 01110010 -> out_data 01110111 with out_valid high 2 cycles after accept.
- ROUNDS=2, decrypt, same key, data 01110111 -> out_data 01110010.
- out_ready held low 10 cycles in DONE -> out_valid and out_data stable, in_ready low; release -> IDLE next cycle, in_ready=1.
- rst asserted on the 2nd ROUND cycle -> next cycle out_valid=0, busy=0, no result ever emitted; a fresh request then completes correctly.
- ROUNDS=4 and ROUNDS=1, 256 random data values x 8 random keys: decrypt(encrypt(d)) == d; latency equals ROUNDS.
- SDES_ABORT_EN: abort pulsed mid-ROUND -> IDLE next cycle, no out_valid; abort with in_valid in IDLE -> no accept.

Source files
------------

// File: rtl/sdes_iter_core_if.sv
// sdes_iter_core_if -- request/result handshake bundle for sdes_iter_core.
//   in_valid/in_ready    : request handshake (producer -> core)
//   in_data [0:7]        : plaintext or ciphertext block, index 0 = MSB
//   in_key  [0:9]        : 10-bit S-DES key, index 0 = MSB
//   in_decrypt           : 0 = encrypt, 1 = decrypt
//   out_valid/out_ready  : result handshake (core -> consumer)
//   out_data [0:7]       : result block
//   busy                 : core is executing rounds
// Modports: master = producer/consumer side, slave = the core.
interface sdes_iter_core_if;
   logic       in_valid;
   logic       in_ready;
   logic [0:7] in_data;
   logic [0:9] in_key;
   logic       in_decrypt;
   logic       out_valid;
   logic       out_ready;
   logic [0:7] out_data;
   logic       busy;

   modport master (output in_valid, in_data, in_key, in_decrypt, out_ready,
                   input  in_ready, out_valid, out_data, busy);
   modport slave  (input  in_valid, in_data, in_key, in_decrypt, out_ready,
                   output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/sdes_iter_core.sv
// sdes_iter_core -- iterative S-DES engine, one Feistel round per clock.
// Parameter ROUNDS (1..16, default 2 = textbook S-DES).
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous reset, active high
//   abort : (only with SDES_ABORT_EN defined) drop the in-flight block
//   bus   : sdes_iter_core_if.slave request/result handshake
// Optional feature macro: SDES_ABORT_EN.
// Bit vectors are declared [0:N] so table entry n maps to index n-1.
module sdes_iter_core #(
   parameter int ROUNDS = 2
) (
   input  logic clk,
   input  logic rst,
`ifdef SDES_ABORT_EN
   input  logic abort,
`endif
   sdes_iter_core_if.slave bus
);

   // cumulative left rotation of the key halves at the last encrypt round
   localparam int SROT = (1 + 2 * (ROUNDS - 1)) % 5;

   // S-box contents, row-major, 2 bits per entry
   localparam logic [0:31] S0_T = {2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                   2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
   localparam logic [0:31] S1_T = {2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                   2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   function automatic logic [0:9] p10(input logic [0:9] k);
      return {k[2], k[4], k[1], k[6], k[3], k[9], k[0], k[8], k[7], k[5]};
   endfunction

   function automatic logic [0:7] p8(input logic [0:9] k);
      return {k[5], k[2], k[6], k[3], k[7], k[4], k[9], k[8]};
   endfunction

   function automatic logic [0:7] ip(input logic [0:7] d);
      return {d[1], d[5], d[2], d[0], d[3], d[7], d[4], d[6]};
   endfunction

   function automatic logic [0:7] ipinv(input logic [0:7] d);
      return {d[3], d[0], d[2], d[4], d[6], d[1], d[7], d[5]};
   endfunction

   function automatic logic [0:7] ep(input logic [0:3] r);
      return {r[3], r[0], r[1], r[2], r[1], r[2], r[3], r[0]};
   endfunction

   function automatic logic [0:3] p4(input logic [0:3] s);
      return {s[1], s[3], s[2], s[0]};
   endfunction

   // row = outer bits, column = inner bits
   function automatic logic [1:0] sbox(input logic [0:31] tbl, input logic [0:3] x);
      logic [3:0] idx;
      idx = {x[0], x[3], x[1], x[2]};
      return tbl[2*idx +: 2];
   endfunction

   // left rotate of a 5-bit half; only ever called with constant amounts
   function automatic logic [0:4] rol5(input logic [0:4] v, input int n);
      logic [0:4] r;
      for (int i = 0; i < 5; i++) r[i] = v[(i + n) % 5];
      return r;
   endfunction

   state_t     state, state_nxt;
   logic [0:7] blk;
   logic [0:4] kl, kr;
   logic [4:0] cnt;
   logic       dec;
   logic [0:7] out_data_q;
   logic       out_valid_q;
   logic       accept, last, kill;
   logic [0:9] p10k;
   logic [0:3] lh, rh, lnew;
   logic [0:7] x;
   logic [0:3] sb;

`ifdef SDES_ABORT_EN
   assign kill         = abort && (state != IDLE);
   assign bus.in_ready = (state == IDLE) && !rst && !abort;
`else
   assign kill         = 1'b0;
   assign bus.in_ready = (state == IDLE) && !rst;
`endif
   assign accept        = bus.in_valid && bus.in_ready;
   assign last          = (cnt == 5'(ROUNDS - 1));
   assign bus.busy      = (state == ROUND);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // round function on the current block and key state
   assign p10k = p10(bus.in_key);
   assign lh   = blk[0:3];
   assign rh   = blk[4:7];
   assign x    = ep(rh) ^ p8({kl, kr});
   assign sb   = {sbox(S0_T, x[0:3]), sbox(S1_T, x[4:7])};
   assign lnew = lh ^ p4(sb);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ROUND;
         ROUND:   if (last) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (kill) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blk         <= '0;
         kl          <= '0;
         kr          <= '0;
         cnt         <= '0;
         dec         <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (kill) begin
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               blk <= ip(bus.in_data);
               dec <= bus.in_decrypt;
               cnt <= '0;
               // decrypt starts from the last encrypt subkey's key state
               if (bus.in_decrypt) begin
                  kl <= rol5(p10k[0:4], SROT);
                  kr <= rol5(p10k[5:9], SROT);
               end else begin
                  kl <= rol5(p10k[0:4], 1);
                  kr <= rol5(p10k[5:9], 1);
               end
            end
            ROUND: if (last) begin
               out_data_q  <= ipinv({lnew, rh});
               out_valid_q <= 1'b1;
            end else begin
               blk <= {rh, lnew};
               cnt <= cnt + 5'd1;
               // rotate right by 2 == rotate left by 3 on 5 bits
               kl  <= dec ? rol5(kl, 3) : rol5(kl, 2);
               kr  <= dec ? rol5(kr, 3) : rol5(kr, 2);
            end
            DONE: if (bus.out_ready) out_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdes_iter_core.sv
// tb_sdes_iter_core -- directed bench for sdes_iter_core.
// Three instances: ROUNDS=2 (unit 0), ROUNDS=4 (unit 1), ROUNDS=1 (unit 2).
module tb_sdes_iter_core;
   localparam int NU = 3;
   localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   localparam int P8_T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
   localparam int IP_T  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
   localparam int IPI_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
   localparam int EP_T  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
   localparam int P4_T  [4]  = '{2, 4, 3, 1};
   localparam int S0_T  [16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
   localparam int S1_T  [16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

   localparam logic [0:9] KEY = 10'b1010000010;
   localparam logic [0:7] PT  = 8'b01110010;
   localparam logic [0:7] CT  = 8'b01110111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [NU-1:0] in_valid, in_decrypt, out_ready;
   logic [NU-1:0] in_ready, out_valid, busy;
   logic [0:7]    in_data  [NU];
   logic [0:9]    in_key   [NU];
   logic [0:7]    out_data [NU];
`ifdef SDES_ABORT_EN
   logic [NU-1:0] abort;
`endif

   int checks   = 0;
   int failures = 0;

   for (genvar g = 0; g < NU; g++) begin : g_u
      sdes_iter_core_if bus ();
      assign bus.in_valid   = in_valid[g];
      assign bus.in_data    = in_data[g];
      assign bus.in_key     = in_key[g];
      assign bus.in_decrypt = in_decrypt[g];
      assign bus.out_ready  = out_ready[g];
      assign in_ready[g]    = bus.in_ready;
      assign out_valid[g]   = bus.out_valid;
      assign out_data[g]    = bus.out_data;
      assign busy[g]        = bus.busy;
      sdes_iter_core #(.ROUNDS(g == 0 ? 2 : (g == 1 ? 4 : 1))) dut (
         .clk   (clk),
         .rst   (rst),
`ifdef SDES_ABORT_EN
         .abort (abort[g]),
`endif
         .bus   (bus)
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference S-DES straight from the tables, subkeys precomputed per round
   function automatic logic [0:7] model(input logic [0:7] d, input logic [0:9] k,
                                        input logic dc, input int rounds);
      logic [0:9] p, rk;
      logic [0:7] sk [16];
      logic [0:7] b, e, x, o;
      logic [0:3] l, r, s, f;
      int rot;
      for (int i = 0; i < 10; i++) p[i] = k[P10_T[i]-1];
      rot = 0;
      for (int n = 1; n <= rounds; n++) begin
         rot += (n == 1) ? 1 : 2;
         for (int i = 0; i < 5; i++) begin
            rk[i]   = p[(i + rot) % 5];
            rk[5+i] = p[5 + (i + rot) % 5];
         end
         for (int i = 0; i < 8; i++) sk[n-1][i] = rk[P8_T[i]-1];
      end
      for (int i = 0; i < 8; i++) b[i] = d[IP_T[i]-1];
      for (int j = 0; j < rounds; j++) begin
         l = b[0:3];
         r = b[4:7];
         for (int i = 0; i < 8; i++) e[i] = r[EP_T[i]-1];
         x = e ^ (dc ? sk[rounds-1-j] : sk[j]);
         s[0:1] = 2'(S0_T[{x[0], x[3], x[1], x[2]}]);
         s[2:3] = 2'(S1_T[{x[4], x[7], x[5], x[6]}]);
         for (int i = 0; i < 4; i++) f[i] = s[P4_T[i]-1];
         l = l ^ f;
         b = (j == rounds - 1) ? {l, r} : {r, l};
      end
      for (int i = 0; i < 8; i++) o[i] = b[IPI_T[i]-1];
      return o;
   endfunction

   // one full transaction on unit u; lat = edges from accept to out_valid
   task automatic run(input int u, input logic [0:7] d, input logic [0:9] k,
                      input logic dc, output logic [0:7] res, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready[u] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(in_ready[u]), 1);
      in_valid[u] = 1'b1; in_data[u] = d; in_key[u] = k; in_decrypt[u] = dc;
      @(posedge clk); #1;
      // scramble inputs after accept; the core must ignore them
      in_valid[u] = 1'b0; in_data[u] = 8'($urandom); in_key[u] = 10'($urandom);
      in_decrypt[u] = ~dc;
      chk("busy_after_accept", 32'(busy[u]), 1);
      n = 0;
      while (!out_valid[u] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      lat = n;
      res = out_data[u];
      out_ready[u] = 1'b1;
      @(posedge clk); #1;
      out_ready[u] = 1'b0;
      chk("out_valid_cleared", 32'(out_valid[u]), 0);
   endtask

   task automatic roundtrip(input int u, input int rounds);
      logic [0:9] k;
      logic [0:7] d, c, p;
      int lat;
      for (int kk = 0; kk < 8; kk++) begin
         k = 10'($urandom);
         for (int j = 0; j < 256; j++) begin
            d = 8'($urandom);
            run(u, d, k, 1'b0, c, lat);
            chk("rt_enc", 32'(c), 32'(model(d, k, 1'b0, rounds)));
            chk("rt_enc_lat", lat, rounds);
            run(u, c, k, 1'b1, p, lat);
            chk("rt_dec", 32'(p), 32'(d));
            chk("rt_dec_lat", lat, rounds);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:7] r, d;
      logic [0:9] k;
      int lat, n;
      rst = 1'b1;
      in_valid = '0; in_decrypt = '0; out_ready = '0;
`ifdef SDES_ABORT_EN
      abort = '0;
`endif
      for (int u = 0; u < NU; u++) begin
         in_data[u] = '0;
         in_key[u]  = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < NU; u++) begin
         chk("rst_in_ready", 32'(in_ready[u]), 0);
         chk("rst_out_valid", 32'(out_valid[u]), 0);
         chk("rst_out_data", 32'(out_data[u]), 0);
         chk("rst_busy", 32'(busy[u]), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", 32'(in_ready[0]), 1);

      // textbook vectors, ROUNDS=2
      run(0, PT, KEY, 1'b0, r, lat);
      chk("enc_textbook", 32'(r), 32'(CT));
      chk("enc_latency", lat, 2);
      run(0, CT, KEY, 1'b1, r, lat);
      chk("dec_textbook", 32'(r), 32'(PT));
      chk("dec_latency", lat, 2);

      // further ROUNDS=2 vectors in both directions
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         k = 10'($urandom);
         run(0, d, k, 1'b0, r, lat);
         chk("enc_vec", 32'(r), 32'(model(d, k, 1'b0, 2)));
         run(0, d, k, 1'b1, r, lat);
         chk("dec_vec", 32'(r), 32'(model(d, k, 1'b1, 2)));
      end

      // back-pressure: hold out_ready low in DONE
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = PT; in_key[0] = KEY; in_decrypt[0] = 1'b0;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("stall_latency", n, 2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid[0] = (i == 5);
         chk("stall_out_valid", 32'(out_valid[0]), 1);
         chk("stall_out_data", 32'(out_data[0]), 32'(CT));
         chk("stall_in_ready", 32'(in_ready[0]), 0);
      end
      @(negedge clk);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      #1;
      chk("release_no_overlap", 32'(in_ready[0]), 0);
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      chk("release_out_valid", 32'(out_valid[0]), 0);
      chk("release_in_ready", 32'(in_ready[0]), 1);
      chk("release_busy", 32'(busy[0]), 0);
      chk("idle_keeps_data", 32'(out_data[0]), 32'(CT));

      // reset during the second ROUND cycle discards the block
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = PT; in_key[0] = KEY; in_decrypt[0] = 1'b0;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out_valid", 32'(out_valid[0]), 0);
      chk("midrst_busy", 32'(busy[0]), 0);
      chk("midrst_in_ready", 32'(in_ready[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_emit", 32'(out_valid[0]), 0);
      end
      run(0, PT, KEY, 1'b0, r, lat);
      chk("after_rst_enc", 32'(r), 32'(CT));
      chk("after_rst_latency", lat, 2);

`ifdef SDES_ABORT_EN
      // abort mid-ROUND
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = PT; in_key[0] = KEY; in_decrypt[0] = 1'b0;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      abort[0]    = 1'b1;
      @(posedge clk); #1;
      abort[0] = 1'b0;
      chk("abort_busy", 32'(busy[0]), 0);
      chk("abort_out_valid", 32'(out_valid[0]), 0);
      chk("abort_in_ready", 32'(in_ready[0]), 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_no_emit", 32'(out_valid[0]), 0);
      end
      // abort in IDLE blocks the accept
      @(negedge clk);
      abort[0] = 1'b1; in_valid[0] = 1'b1;
      #1;
      chk("abort_idle_ready", 32'(in_ready[0]), 0);
      @(posedge clk); #1;
      abort[0] = 1'b0; in_valid[0] = 1'b0;
      chk("abort_idle_no_accept", 32'(busy[0]), 0);
      chk("abort_idle_in_ready", 32'(in_ready[0]), 1);
`endif

      // round-trip on ROUNDS=4 and ROUNDS=1 in parallel
      fork
         roundtrip(1, 4);
         roundtrip(2, 1);
      join

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
